// File: rtl/strt_bit_validator.sv
// -----------------------------------------------------------------------------
// strt_bit_validator
//   UART RX start-bit detector/validator with oversampling. A falling edge on
//   the serial line starts a bit-time counter. Three samples taken around the
//   bit centre are majority-voted. A low vote confirms the start bit with a
//   one-cycle o_strt_valid pulse, and the block then holds until the frame
//   FSM reports frame end. A high vote rejects the start bit with a one-cycle
//   o_strt_glitch pulse, and the block then waits for the line to return idle.
//
// Configuration macro:
//   STRT_INPUT_SYNC_EN - when defined, i_rx_in passes through a 2-flop
//                        synchroniser (reset to 1). All latencies grow by 2.
//                        When undefined, i_rx_in must be synchronous to i_clk.
//
// Ports:
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_en           block enable; low forces IDLE on the next clock
//   i_rx_in        serial line, idle high
//   i_prescale     oversampling clocks per bit, latched at edge detection
//   i_frame_done   frame FSM pulse: frame finished, re-arm detector
//   o_strt_valid   1-cycle pulse: start bit confirmed (vote = 0)
//   o_strt_glitch  1-cycle pulse: start bit rejected (vote = 1)
//   o_sampled_bit  last vote result, held until the next vote
//   o_busy         high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module strt_bit_validator #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int MIN_PRESCALE   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_rx_in,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic                      i_frame_done,
  output logic                      o_strt_valid,
  output logic                      o_strt_glitch,
  output logic                      o_sampled_bit,
  output logic                      o_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_LOCKED = 2'd2,
    S_REARM  = 2'd3
  } state_t;

  localparam logic [PRESCALE_WIDTH-1:0] MIN_PS  = PRESCALE_WIDTH'(MIN_PRESCALE);
  localparam logic [PRESCALE_WIDTH-1:0] ZERO_PS = {PRESCALE_WIDTH{1'b0}};
  localparam logic [PRESCALE_WIDTH-1:0] ONE_PS  = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t                    r_state;
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic [PRESCALE_WIDTH-1:0] r_ps;
  logic                      r_samp0;
  logic                      r_samp1;
  logic                      r_strt_valid;
  logic                      r_strt_glitch;
  logic                      r_sampled_bit;
  logic                      r_busy;

  logic                      w_rx;
  logic [PRESCALE_WIDTH-1:0] w_ps_clamped;
  logic [PRESCALE_WIDTH-1:0] w_mid;
  logic [PRESCALE_WIDTH-1:0] w_mid_m1;
  logic [PRESCALE_WIDTH-1:0] w_mid_p1;
  logic                      w_vote;

`ifdef STRT_INPUT_SYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rx_in};
    end
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = i_rx_in;
`endif

  // Prescale below the minimum is raised to the minimum before latching.
  assign w_ps_clamped = (i_prescale < MIN_PS) ? MIN_PS : i_prescale;
  // Sample points are derived from the latched prescale, so prescale changes
  // during COUNT have no effect on the current vote.
  assign w_mid    = r_ps >> 1;
  assign w_mid_m1 = w_mid - ONE_PS;
  assign w_mid_p1 = w_mid + ONE_PS;
  // Third sample is the live line value at the mid+1 count.
  assign w_vote   = maj3(r_samp0, r_samp1, w_rx);

  // Start-bit FSM with registered pulse, vote and busy outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= ZERO_PS;
      r_ps          <= MIN_PS;
      r_samp0       <= 1'b1;
      r_samp1       <= 1'b1;
      r_strt_valid  <= 1'b0;
      r_strt_glitch <= 1'b0;
      r_sampled_bit <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      r_strt_valid  <= 1'b0;
      r_strt_glitch <= 1'b0;
      if (!i_en) begin
        r_state <= S_IDLE;
        r_cnt   <= ZERO_PS;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!w_rx) begin
              // Detection cycle counts as 0, so COUNT starts at 1.
              r_state <= S_COUNT;
              r_cnt   <= ONE_PS;
              r_ps    <= w_ps_clamped;
              r_busy  <= 1'b1;
            end else begin
              r_cnt  <= ZERO_PS;
              r_busy <= 1'b0;
            end
          end
          S_COUNT: begin
            r_cnt <= r_cnt + ONE_PS;
            if (r_cnt == w_mid_m1) begin
              r_samp0 <= w_rx;
            end
            if (r_cnt == w_mid) begin
              r_samp1 <= w_rx;
            end
            if (r_cnt == w_mid_p1) begin
              r_cnt         <= ZERO_PS;
              r_sampled_bit <= w_vote;
              if (w_vote) begin
                r_strt_glitch <= 1'b1;
                r_state       <= S_REARM;
              end else begin
                r_strt_valid <= 1'b1;
                r_state      <= S_LOCKED;
              end
            end
          end
          S_LOCKED: begin
            if (i_frame_done) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          S_REARM: begin
            // No new edge detection until the line has returned idle.
            if (w_rx) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= ZERO_PS;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_strt_valid  = r_strt_valid;
  assign o_strt_glitch = r_strt_glitch;
  assign o_sampled_bit = r_sampled_bit;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_strt_bit_validator.sv
module tb_strt_bit_validator;

`ifdef STRT_INPUT_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rx;
  logic [5:0] prescale;
  logic       frame_done;
  logic       o_strt_valid;
  logic       o_strt_glitch;
  logic       o_sampled_bit;
  logic       o_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit kind;   // 0 = valid, 1 = glitch
    int cyc;
  } exp_t;
  exp_t sb[$];

  strt_bit_validator #(.PRESCALE_WIDTH(6), .MIN_PRESCALE(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_rx_in       (rx),
    .i_prescale    (prescale),
    .i_frame_done  (frame_done),
    .o_strt_valid  (o_strt_valid),
    .o_strt_glitch (o_strt_glitch),
    .o_sampled_bit (o_sampled_bit),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pulse must match the next expected pulse kind and cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (o_strt_valid !== 1'b0 || o_strt_glitch !== 1'b0)) begin
      checks++;
      if (o_strt_valid === 1'b1 && o_strt_glitch === 1'b1) begin
        errors++;
        $display("FAIL pulse_exclusive: valid=%b glitch=%b, required not both high at cycle %0d",
                 o_strt_valid, o_strt_glitch, cyc);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: valid=%b glitch=%b at cycle %0d, required no pulse",
                 o_strt_valid, o_strt_glitch, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (o_strt_glitch !== e.kind || cyc != e.cyc) begin
          errors++;
          $display("FAIL pulse_match: got glitch=%b at cycle %0d, required glitch=%b at cycle %0d",
                   o_strt_glitch, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input bit kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic drive_pattern(input logic [15:0] pat, input int len);
    logic [15:0] p;
    p = pat;
    for (int i = 0; i < len; i++) begin
      rx = p[i];
      tick(1);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; rx = 1'b1; frame_done = 1'b0; prescale = 6'd8;
    tick(3);
    checks++; if (o_strt_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b, required 0", o_strt_valid); end
    checks++; if (o_strt_glitch !== 1'b0) begin errors++; $display("FAIL reset_glitch: got %b, required 0", o_strt_glitch); end
    checks++; if (o_sampled_bit !== 1'b1) begin errors++; $display("FAIL reset_sampled: got %b, required 1", o_sampled_bit); end
    checks++; if (o_busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
    rst_n = 1'b1; en = 1'b1;
    tick(2);
  endtask

  task automatic test_frame_done_release(input string name);
    rx = 1'b1;
    tick(3);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL %s_locked_busy: got %b, required 1", name, o_busy); end
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL %s_release_busy: got %b, required 0", name, o_busy); end
    tick(2);
  endtask

  task automatic test_valid_ps8;
    int c;
    c = cyc;
    prescale = 6'd8;
    expect_pulse(1'b0, c + 6 + L);
    for (int i = 0; i < 8; i++) begin
      rx = 1'b0;
      if (i == 3) prescale = 6'd16;   // must not affect the latched value
      tick(1);
    end
    rx = 1'b1;
    tick(2);
    checks++; if (o_sampled_bit !== 1'b0) begin errors++; $display("FAIL valid8_sampled: got %b, required 0", o_sampled_bit); end
    checks++; if (o_busy !== 1'b1)        begin errors++; $display("FAIL valid8_busy: got %b, required 1", o_busy); end
    // LOCKED ignores line activity.
    for (int i = 0; i < 6; i++) begin
      rx = i[0];
      tick(1);
    end
    test_frame_done_release("valid8");
  endtask

  task automatic test_glitch_ps8;
    int c;
    c = cyc;
    prescale = 6'd8;
    expect_pulse(1'b1, c + 6 + L);
    for (int i = 0; i < 8; i++) begin
      rx = (i < 2) ? 1'b0 : 1'b1;
      frame_done = (i == 3) ? 1'b1 : 1'b0;   // ignored outside LOCKED
      tick(1);
    end
    frame_done = 1'b0;
    rx = 1'b1;
    tick(L);
    checks++; if (o_sampled_bit !== 1'b1) begin errors++; $display("FAIL glitch8_sampled: got %b, required 1", o_sampled_bit); end
    checks++; if (o_busy !== 1'b0)        begin errors++; $display("FAIL glitch8_rearm_idle: got %b, required 0", o_busy); end
    tick(2);
  endtask

  task automatic test_majority_ps16;
    int c;
    // Single high at the centre sample: 0,1,0 votes 0.
    c = cyc;
    prescale = 6'd16;
    expect_pulse(1'b0, c + 10 + L);
    drive_pattern(16'h0100, 12);
    tick(L);
    checks++; if (o_sampled_bit !== 1'b0) begin errors++; $display("FAIL maj16_valid_sampled: got %b, required 0", o_sampled_bit); end
    test_frame_done_release("maj16");
    // Highs at the outer samples: 1,0,1 votes 1; line stays low afterwards.
    c = cyc;
    expect_pulse(1'b1, c + 10 + L);
    drive_pattern(16'h0280, 12);
    tick(L);
    checks++; if (o_busy !== 1'b1)        begin errors++; $display("FAIL maj16_rearm_wait: got %b, required 1", o_busy); end
    checks++; if (o_sampled_bit !== 1'b1) begin errors++; $display("FAIL maj16_glitch_sampled: got %b, required 1", o_sampled_bit); end
    tick(1);
    checks++; if (o_busy !== 1'b0)        begin errors++; $display("FAIL maj16_rearm_idle: got %b, required 0", o_busy); end
    tick(2);
  endtask

  task automatic test_min_prescale;
    int c;
    c = cyc;
    prescale = 6'd2;   // clamped to 4: mid = 2, pulse at cycle 4
    expect_pulse(1'b0, c + 4 + L);
    drive_pattern(16'h0000, 6);
    test_frame_done_release("minps");
  endtask

  task automatic test_en_low;
    int c;
    prescale = 6'd8;
    rx = 1'b0;
    tick(3);
    en = 1'b0;
    tick(1);
    checks++; if (o_busy !== 1'b0)        begin errors++; $display("FAIL en_low_busy: got %b, required 0", o_busy); end
    tick(8);   // a pulse here would be flagged by the scoreboard
    checks++; if (o_sampled_bit !== 1'b0) begin errors++; $display("FAIL en_low_sampled_hold: got %b, required 0", o_sampled_bit); end
    // Re-enable with the line already low: immediate new detection.
    c = cyc;
    expect_pulse(1'b0, c + 6);
    en = 1'b1;
    drive_pattern(16'h0000, 8);
    test_frame_done_release("en_reassert");
  endtask

  task automatic test_reset_mid;
    prescale = 6'd8;
    rx = 1'b0;
    tick(3 + L);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (o_strt_valid !== 1'b0)  begin errors++; $display("FAIL rstmid_valid: got %b, required 0", o_strt_valid); end
    checks++; if (o_strt_glitch !== 1'b0) begin errors++; $display("FAIL rstmid_glitch: got %b, required 0", o_strt_glitch); end
    checks++; if (o_sampled_bit !== 1'b1) begin errors++; $display("FAIL rstmid_sampled: got %b, required 1", o_sampled_bit); end
    checks++; if (o_busy !== 1'b0)        begin errors++; $display("FAIL rstmid_busy: got %b, required 0", o_busy); end
    rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_valid_ps8();
    test_glitch_ps8();
    test_majority_ps16();
    test_min_prescale();
    test_en_low();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
